// File: rtl/uart_host_link_if.sv
// Job and UART byte-level signals between the host link and its environment.
// The master modport is the host link; the slave side is the job issuer plus UART.
interface uart_host_link_if #(
  parameter int HEADER_BYTES = 80
);
  logic                      start;
  logic [HEADER_BYTES*8-1:0] header;
  logic                      busy;
  logic [31:0]               nonce;
  logic                      nonce_valid;
  logic                      fail;
  logic [7:0]                tx;
  logic                      txce;
  logic                      is_transmitting;
  logic [7:0]                rx;
  logic                      rxce;
  logic                      error;

  modport master (
    input  start, header, is_transmitting, rx, rxce, error,
    output busy, nonce, nonce_valid, fail, tx, txce
  );

  modport slave (
    output start, header, is_transmitting, rx, rxce, error,
    input  busy, nonce, nonce_valid, fail, tx, txce
  );
endinterface

// File: rtl/uart_host_link.sv
// Host side of the miner serial link: streams a block header out MSB-first,
// then assembles the 4-byte nonce reply, with timeout and framing-error abort.
module uart_host_link #(
  parameter int HEADER_BYTES   = 80,
  parameter int NONCE_BYTES    = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  uart_host_link_if.master bus
);
  localparam int HW = HEADER_BYTES * 8;
  localparam int CW = $clog2(HEADER_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_RX_NONCE} state_t;

  state_t        r_state;
  logic [HW-1:0] r_hdr;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_acc;
  logic [31:0]   r_nonce;
  logic [7:0]    r_tx;
  logic          r_txce;
  logic          r_busy;
  logic          r_valid;
  logic          r_fail;
  logic          w_tmo_hit;

  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_hdr   <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_acc   <= '0;
      r_nonce <= '0;
      r_tx    <= '0;
      r_txce  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_txce  <= 1'b0;
      r_valid <= 1'b0;
      r_fail  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (bus.start) begin
            r_hdr   <= bus.header;
            r_tx    <= bus.header[HW-1 -: 8];
            r_txce  <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(1);
            r_state <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (bus.is_transmitting) begin
            r_tmo   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (w_tmo_hit) begin
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!bus.is_transmitting) begin
            r_tmo <= '0;
            if (r_cnt < CW'(HEADER_BYTES)) begin
              // r_hdr keeps the byte already on tx at its top; send the one below it
              r_hdr   <= {r_hdr[HW-9:0], 8'h00};
              r_tx    <= r_hdr[HW-9 -: 8];
              r_txce  <= 1'b1;
              r_cnt   <= r_cnt + CW'(1);
              r_state <= S_WAIT_BUSY;
            end else begin
              r_cnt   <= '0;
              r_acc   <= '0;
              r_state <= S_RX_NONCE;
            end
          end else if (w_tmo_hit) begin
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_RX_NONCE: begin
          // a framing error discards the byte arriving with it
          if (bus.error || (!bus.rxce && w_tmo_hit)) begin
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else if (bus.rxce) begin
            r_acc <= {r_acc[23:0], bus.rx};
            r_tmo <= '0;
            if (r_cnt == CW'(NONCE_BYTES - 1)) begin
              r_nonce <= {r_acc[23:0], bus.rx};
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx          = r_tx;
  assign bus.txce        = r_txce;
  assign bus.busy        = r_busy;
  assign bus.nonce       = r_nonce;
  assign bus.nonce_valid = r_valid;
  assign bus.fail        = r_fail;
endmodule

// File: tb/tb_uart_host_link.sv
// Bench for uart_host_link: behavioural UART transmitter, expected tx bytes and
// nonces queued as jobs are driven and popped as the link produces them.
module tb_uart_host_link;
  localparam int HB  = 80;
  localparam int NB  = 4;
  localparam int TMO = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_host_link_if #(.HEADER_BYTES(HB)) bus ();

  uart_host_link #(
    .HEADER_BYTES  (HB),
    .NONCE_BYTES   (NB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_bad    = 0;
  int tx_cnt   = 0;
  int fail_cnt = 0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_nonce[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART transmitter: goes busy on the negedge after a strobe, for 10 cycles
  logic u_busy = 1'b0;
  int   u_cnt  = 0;
  assign bus.is_transmitting = u_busy;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_busy <= 1'b0;
      u_cnt  <= 0;
    end else if (u_cnt > 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) u_busy <= 1'b0;
    end else if (bus.txce) begin
      u_busy <= 1'b1;
      u_cnt  <= 10;
    end
  end

  // scoreboard side
  always @(posedge clk) begin
    logic [7:0]  etx;
    logic [31:0] enc;
    #1;
    if (rst_n) begin
      if (bus.txce) begin
        tx_cnt++;
        chk("txce_while_busy", 64'(bus.is_transmitting), 64'(0));
        etx = (exp_tx.size() > 0) ? exp_tx.pop_front() : ~bus.tx;
        chk("tx_byte", 64'(bus.tx), 64'(etx));
      end
      if (bus.nonce_valid) begin
        enc = (exp_nonce.size() > 0) ? exp_nonce.pop_front() : ~bus.nonce;
        chk("nonce_sb", 64'(bus.nonce), 64'(enc));
      end
      if (bus.fail) fail_cnt++;
    end
  end

  task automatic start_job(input logic [HB*8-1:0] h);
    for (int i = 0; i < HB; i++) exp_tx.push_back(h[HB*8-1-8*i -: 8]);
    tx_cnt     = 0;
    bus.header = h;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("first_txce", 64'(bus.txce), 64'(1));
    chk("first_busy", 64'(bus.busy), 64'(1));
    chk("first_tx",   64'(bus.tx),   64'(h[HB*8-1 -: 8]));
  endtask

  task automatic wait_tx(input bit stray);
    int g;
    g = 0;
    while (tx_cnt < HB && g < 3000) begin
      @(negedge clk);
      g++;
      if (stray && g == 30) begin
        bus.rx = 8'hFF; bus.rxce = 1'b1; bus.error = 1'b1;
      end else begin
        bus.rxce = 1'b0; bus.error = 1'b0;
      end
    end
    bus.rxce = 1'b0; bus.error = 1'b0;
    while (!bus.is_transmitting && g < 3000) begin @(negedge clk); g++; end
    while (bus.is_transmitting && g < 3000) begin @(negedge clk); g++; end
    @(negedge clk);
    chk("tx_count", 64'(tx_cnt), 64'(HB));
    chk("tx_idle", 64'(bus.is_transmitting), 64'(0));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    bus.rx = b; bus.rxce = 1'b1; bus.error = err;
    @(negedge clk);
    bus.rxce = 1'b0; bus.error = 1'b0;
  endtask

  task automatic reply(input logic [31:0] n);
    for (int k = 0; k < NB; k++) begin
      if (k == NB - 1) exp_nonce.push_back(n);
      send_byte(n[31-8*k -: 8], 1'b0);
      if (k < NB - 1) repeat (3) @(negedge clk);
    end
    chk("nv_pulse",  64'(bus.nonce_valid), 64'(1));
    chk("busy_fall", 64'(bus.busy),        64'(0));
    chk("nonce_out", 64'(bus.nonce),       64'(n));
    @(negedge clk);
    chk("nv_single", 64'(bus.nonce_valid), 64'(0));
  endtask

  initial begin
    logic [HB*8-1:0] h1, h2;
    int i;
    bus.start = 1'b0; bus.header = '0; bus.rx = '0; bus.rxce = 1'b0; bus.error = 1'b0;
    h1 = {HB{8'hA5}};
    h1[7:0] = 8'h3C;
    for (int k = 0; k < HB; k++) h2[8*k +: 8] = 8'(k * 7 + 1);

    repeat (3) @(negedge clk);
    chk("rst_tx",    64'(bus.tx),          64'(0));
    chk("rst_txce",  64'(bus.txce),        64'(0));
    chk("rst_busy",  64'(bus.busy),        64'(0));
    chk("rst_nonce", 64'(bus.nonce),       64'(0));
    chk("rst_nv",    64'(bus.nonce_valid), 64'(0));
    chk("rst_fail",  64'(bus.fail),        64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // basic job, A5.. header ending in 3C
    start_job(h1);
    wait_tx(1'b0);
    reply(32'h12345678);

    // stray byte plus error during the header phase are ignored
    start_job(h2);
    wait_tx(1'b1);
    reply(32'hDEADBEEF);
    chk("no_fail_yet", 64'(fail_cnt), 64'(0));

    // silence after two reply bytes
    start_job(h1);
    wait_tx(1'b0);
    send_byte(8'hAB, 1'b0);
    repeat (3) @(negedge clk);
    send_byte(8'hCD, 1'b0);
    i = 0;
    while (!bus.fail && i < 300) begin @(negedge clk); i++; end
    chk("tmo_delay", 64'(i),         64'(100));
    chk("tmo_busy",  64'(bus.busy),  64'(0));
    chk("tmo_nonce", 64'(bus.nonce), 64'(32'hDEADBEEF));
    @(negedge clk);
    chk("tmo_fail_single", 64'(bus.fail), 64'(0));

    // framing error on the third reply byte, then an immediate new job
    start_job(h2);
    wait_tx(1'b0);
    send_byte(8'h11, 1'b0);
    repeat (2) @(negedge clk);
    send_byte(8'h22, 1'b0);
    repeat (2) @(negedge clk);
    send_byte(8'h33, 1'b1);
    chk("err_fail",  64'(bus.fail),  64'(1));
    chk("err_busy",  64'(bus.busy),  64'(0));
    chk("err_nonce", 64'(bus.nonce), 64'(32'hDEADBEEF));
    start_job(h1);
    wait_tx(1'b0);
    reply(32'hCAFEF00D);
    chk("fail_count", 64'(fail_cnt), 64'(2));

    // reset in the middle of the header
    start_job(h2);
    i = 0;
    while (tx_cnt < 40 && i < 2000) begin @(negedge clk); i++; end
    chk("mid_hdr_reached", 64'(tx_cnt), 64'(40));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txce",  64'(bus.txce),  64'(0));
    chk("mid_rst_busy",  64'(bus.busy),  64'(0));
    chk("mid_rst_nonce", 64'(bus.nonce), 64'(0));
    exp_tx.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(h1);
    wait_tx(1'b0);
    reply(32'h0BADC0DE);

    chk("tx_queue_empty",    64'(exp_tx.size()),    64'(0));
    chk("nonce_queue_empty", 64'(exp_nonce.size()), 64'(0));
    chk("fail_count_end",    64'(fail_cnt),         64'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_host_link.md
# uart_host_link

Host-side counterpart of the miner's serial link. It drives the same byte-level `uart` block from the other end: on `start` it streams an 80-byte block header MSB-first out of the UART transmitter, then collects the 4-byte nonce reply from the UART receiver. It delivers the nonce as one 32-bit word with a single-cycle valid strobe. Used as a second-board host / loopback partner and as the bench driver for the miner core.

## Interface
- `HEADER_BYTES`, 80, number of header bytes sent per job.
- `NONCE_BYTES`, 4, number of reply bytes assembled into `nonce`.
- `TIMEOUT_CYCLES`, 50000000, maximum idle cycles in any waiting state; 1 s at 50 MHz.
- `clock` in 1 — single clock domain; the `uart` instance runs on the same clock.
- `reset` in 1 — asynchronous, active-low.
- `start` in 1 — begin a job; sampled only in IDLE.
- `header` in 640 — header word; latched on accepted `start`.
- `tx` out 8 — byte to the UART transmitter.
- `txce` out 1 — single-cycle transmit strobe.
- `is_transmitting` in 1 — UART transmitter busy.
- `rx` in 8 — received byte.
- `rxce` in 1 — single-cycle received-byte strobe.
- `error` in 1 — UART receive framing error.
- `busy` out 1 — job in progress.
- `nonce` out 32 — assembled reply; holds until the next `nonce_valid`.
- `nonce_valid` out 1 — single-cycle strobe when `nonce` is updated.
- `fail` out 1 — single-cycle strobe on timeout or error abort.

## Operation
- **Reset values:** state IDLE; `tx`=0, `txce`=0, `busy`=0, `nonce`=0, `nonce_valid`=0, `fail`=0; byte and timeout counters 0.
- **IDLE:** on `start`=1:
  - latch `header` into an internal 640-bit shift register;
  - drive `tx`=`header[639:632]`, `txce`=1, `busy`=1;
  - go to WAIT_BUSY with byte count 1.
- **WAIT_BUSY:** wait for `is_transmitting`=1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `is_transmitting`=0.
  - If byte count < `HEADER_BYTES`: shift the header left 8, pulse `txce` with the next top byte, increment the count, return to WAIT_BUSY.
  - Else: clear the count and go to RX_NONCE.
- **RX_NONCE:** on each `rxce`, update `nonce_acc = {nonce_acc[23:0], rx}`.
  - The first received byte becomes `nonce[31:24]`.
  - After the `NONCE_BYTES`-th byte: load `nonce` from the accumulator, pulse `nonce_valid`, drop `busy`, return to IDLE.
- **Ignored inputs:**
  - `rxce` outside RX_NONCE: byte discarded, no state change.
  - `start` while `busy`=1.
- **Error:** `error`=1 in RX_NONCE aborts the job: pulse `fail`, `busy`=0, go to IDLE, `nonce` unchanged, partial accumulator discarded. `error` in the TX states is ignored.
- **Timeout:**
  - The counter increments every cycle in WAIT_BUSY, WAIT_DONE and RX_NONCE.
  - It clears on every state transition and on every accepted `rxce`.
  - Reaching `TIMEOUT_CYCLES`-1 aborts exactly as `error` does.
- **Byte counter width:** `$clog2(HEADER_BYTES+1)`. Timeout counter width: `$clog2(TIMEOUT_CYCLES)`. No wrap is possible in either.
- **Reset assertion at any point:** immediately returns all outputs to reset values; the job is lost and no `fail` pulse is produced.

## Timing
- Edge k samples `start`=1 in IDLE. In the cycle after edge k: `txce`=1, `tx`=byte 0, `busy`=1.
- `txce` is high for exactly one cycle per byte. `tx` is held stable until the next `txce`.
- Next-byte strobe: one cycle after the edge that samples `is_transmitting`=0 in WAIT_DONE.
- Final `rxce` sampled at edge m: `nonce`, `nonce_valid`=1 and `busy`=0 are all visible after edge m. `nonce_valid` is low again after edge m+1.
- `start` sampled at edge m+1 is accepted; back-to-back jobs are allowed.
- `rxce` and `error` in the same cycle: `error` wins; the byte is discarded and the job aborts.

## Test plan
- Header `{80{8'hA5}}` with the last byte set to 8'h3C, UART model busy 10 cycles per byte:
  - exactly 80 `txce` pulses; first byte A5, last byte 3C;
  - no `txce` while `is_transmitting`=1.
- Reply bytes 12, 34, 56, 78 after the TX phase -> `nonce`=32'h12345678, a single `nonce_valid` pulse, `busy` falls the same cycle.
- `rxce`=1 with rx=FF during the TX phase, then reply DE AD BE EF -> `nonce`=32'hDEADBEEF (stray byte ignored).
- `TIMEOUT_CYCLES`=100; two reply bytes, then silence -> `fail` pulses 100 cycles after the second byte; `nonce` keeps its previous value.
- `error` with the third reply byte -> `fail` pulse, IDLE. A new `start` is accepted next cycle, and a full job then completes normally.
- `reset` low mid-header at byte 40 -> `txce`=0, `busy`=0 immediately. After release, `start` sends byte 0 again.
